// File: rtl/svo_tmds_dec_pkg.sv
// ----------------------------------------------------------------------------
// svo_tmds_dec_pkg
//   Definitions shared by the TMDS receive decoder and its symbol decoder:
//   the four TMDS control tokens, the word-alignment FSM state encoding and
//   the decoded-symbol record passed between the symbol decoder and the
//   pipeline.
// ----------------------------------------------------------------------------
package svo_tmds_dec_pkg;

    // Control tokens as they appear on the wire (bit 0 transmitted first).
    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic       is_tok;   // word is one of the four control tokens
        logic [1:0] ctrl;     // {c1,c0} when is_tok, else 0
        logic [7:0] data;     // decoded byte when !is_tok, else 0
    } tmds_sym_t;

    // Returns {hit, c1, c0}; hit=0 for any non-token word.
    function automatic logic [2:0] tmds_ctrl_lookup(input logic [9:0] word);
        case (word)
            TMDS_CTRL_00: return 3'b100;
            TMDS_CTRL_01: return 3'b101;
            TMDS_CTRL_10: return 3'b110;
            TMDS_CTRL_11: return 3'b111;
            default:      return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/svo_tmds_dec_sym.sv
// ----------------------------------------------------------------------------
// svo_tmds_sym_dec
//   Purely combinational TMDS symbol decoder: classifies a 10-bit symbol as a
//   control token or a data word and recovers the 8-bit pixel byte.
//
//   Ports
//     word  in   10-bit symbol, bit 0 = first bit on the wire
//     sym   out  decoded record {is_tok, ctrl, data}
// ----------------------------------------------------------------------------
module svo_tmds_sym_dec
    import svo_tmds_dec_pkg::*;
(
    input  logic [9:0] word,
    output tmds_sym_t  sym
);

    logic [2:0] tok;
    logic [7:0] d;
    logic [7:0] dec;

    always_comb begin
        tok = tmds_ctrl_lookup(word);

        // Undo the optional DC-balance inversion first.
        d = word[9] ? ~word[7:0] : word[7:0];

        // Undo the transition-minimising chain. Bit 8 selects XOR (1) or
        // XNOR (0); XNOR is XOR with the result inverted, hence the mask.
        dec = {d[7:1] ^ d[6:0] ^ {7{~word[8]}}, d[0]};

        sym.is_tok = tok[2];
        sym.ctrl   = tok[1:0];
        sym.data   = tok[2] ? '0 : dec;
    end

endmodule

// File: rtl/svo_tmds_dec.sv
// ----------------------------------------------------------------------------
// svo_tmds_dec
//   Single-lane TMDS receive decoder. Decodes deserialised 10-bit symbols to
//   DE / control / pixel byte with a fixed two-cycle latency, and aligns the
//   word boundary by pulsing the deserialiser bitslip input until a run of
//   control tokens is seen.
//
//   Ports
//     clk        in   pixel clock
//     reset      in   synchronous, active-high reset
//     in_valid   in   in_word qualifier
//     in_word    in   10-bit symbol, bit 0 = first bit on the wire
//     bitslip    out  one-cycle pulse to the deserialiser CALIB input
//     locked     out  word alignment achieved
//     out_valid  out  decoded output qualifier (in_valid delayed 2)
//     out_de     out  1 = data symbol, 0 = control token
//     out_ctrl   out  control bits {c1,c0}, meaningful when out_de=0
//     out_data   out  decoded byte, 0 when out_de=0
// ----------------------------------------------------------------------------
module svo_tmds_dec
    import svo_tmds_dec_pkg::*;
#(
    parameter int unsigned TOKEN_RUN      = 8,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned SLIP_WAIT      = 16
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [9:0] in_word,
    output logic       bitslip,
    output logic       locked,
    output logic       out_valid,
    output logic       out_de,
    output logic [1:0] out_ctrl,
    output logic [7:0] out_data
);

    localparam int unsigned RW = $clog2(TOKEN_RUN + 1);
    localparam int unsigned TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int unsigned WW = $clog2(SLIP_WAIT + 1);

    localparam logic [RW-1:0] RUN_MAX   = RW'(TOKEN_RUN);
    localparam logic [RW-1:0] RUN_PRE   = RW'(TOKEN_RUN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

    // ------------------------------------------------------------------
    // Symbol decode on the incoming word
    // ------------------------------------------------------------------
    tmds_sym_t in_sym;

    svo_tmds_sym_dec u_sym (
        .word (in_word),
        .sym  (in_sym)
    );

    // ------------------------------------------------------------------
    // Two-stage datapath. Payload registers only load on valid beats so
    // the outputs hold their last decoded value between beats.
    // ------------------------------------------------------------------
    logic      s1_valid;
    tmds_sym_t s1_sym;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sym   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_sym <= in_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_de    <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_de   <= ~s1_sym.is_tok;
                out_ctrl <= s1_sym.ctrl;
                out_data <= s1_sym.data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word-alignment control
    // ------------------------------------------------------------------
    dec_state_t     state, state_nxt;
    logic [RW-1:0]  run_cnt, run_nxt;
    logic [TW-1:0]  tmo_cnt, tmo_nxt;
    logic [WW-1:0]  wait_cnt, wait_nxt;
    logic           slip_nxt;
    logic           run_hit;
    logic           tmo_hit;

    // run_hit fires on the valid token that brings (or keeps) the run at
    // TOKEN_RUN, so lock and timeout-clearing act in the same cycle the
    // counter reaches its target rather than one cycle later.
    always_comb begin
        run_hit = in_valid && in_sym.is_tok && (run_cnt >= RUN_PRE);
        tmo_hit = in_valid && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_SEARCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        slip_nxt  = 1'b0;
        case (state)
            ST_SEARCH: begin
                // Run completion takes priority over a coincident timeout.
                if (run_hit) begin
                    state_nxt = ST_LOCKED;
                end else if (tmo_hit) begin
                    state_nxt = ST_SLIP_WAIT;
                    slip_nxt  = 1'b1;
                end
            end
            ST_SLIP_WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_nxt = ST_SEARCH;
            end
            ST_LOCKED: begin
                if (!run_hit && tmo_hit)
                    state_nxt = ST_SEARCH;
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    always_comb begin
        // Token run: counts consecutive valid tokens, saturating; held at
        // zero across the slip hold-off since the framing is in flux.
        run_nxt = run_cnt;
        if (state == ST_SLIP_WAIT || state_nxt == ST_SLIP_WAIT)
            run_nxt = '0;
        else if (in_valid)
            run_nxt = !in_sym.is_tok  ? '0 :
                      (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RW'(1);

        // Timeout: valid words since the last qualifying run or state change.
        tmo_nxt = tmo_cnt;
        if (state_nxt != state || run_hit)
            tmo_nxt = '0;
        else if (state != ST_SLIP_WAIT && in_valid)
            tmo_nxt = tmo_cnt + TW'(1);

        // Hold-off: every cycle spent in SLIP_WAIT.
        wait_nxt = wait_cnt;
        if (state_nxt != state)
            wait_nxt = '0;
        else if (state == ST_SLIP_WAIT)
            wait_nxt = wait_cnt + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt  <= '0;
            tmo_cnt  <= '0;
            wait_cnt <= '0;
            bitslip  <= 1'b0;
        end else begin
            run_cnt  <= run_nxt;
            tmo_cnt  <= tmo_nxt;
            wait_cnt <= wait_nxt;
            bitslip  <= slip_nxt;
        end
    end

    always_comb locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_svo_tmds_dec.sv
module tb_svo_tmds_dec;

    localparam int unsigned TOKEN_RUN      = 8;
    localparam int unsigned SEARCH_TIMEOUT = 2048;
    localparam int unsigned SLIP_WAIT      = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [9:0] in_word;
    logic       bitslip;
    logic       locked;
    logic       out_valid;
    logic       out_de;
    logic [1:0] out_ctrl;
    logic [7:0] out_data;

    svo_tmds_dec #(
        .TOKEN_RUN      (TOKEN_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .bitslip   (bitslip),
        .locked    (locked),
        .out_valid (out_valid),
        .out_de    (out_de),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
    } exp_t;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t p1 = '0;
    exp_t p2 = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Forward half of the TMDS encoder: byte -> transition-minimised byte.
    function automatic logic [7:0] qm(input logic [7:0] b, input logic xor_mode);
        logic [7:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++)
            q[i] = xor_mode ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        return q;
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
        int         n1;
        logic       xm;
        logic [7:0] q;
        n1 = $countones(b);
        xm = !(n1 > 4 || (n1 == 4 && b[0] == 1'b0));
        q  = qm(b, xm);
        return inv ? {1'b1, xm, ~q} : {1'b0, xm, q};
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Reference decode: tokens by table, data by searching for the byte
    // whose encoding produces the received word.
    function automatic exp_t model(input logic v, input logic [9:0] w);
        exp_t       e;
        logic [7:0] d;
        e   = '0;
        e.v = v;
        case (w)
            10'h354: e.ctrl = 2'b00;
            10'h0AB: e.ctrl = 2'b01;
            10'h154: e.ctrl = 2'b10;
            10'h2AB: e.ctrl = 2'b11;
            default: begin
                e.de = 1'b1;
                d = w[9] ? ~w[7:0] : w[7:0];
                for (int b = 0; b < 256; b++)
                    if (qm(8'(b), w[8]) == d)
                        e.data = 8'(b);
            end
        endcase
        return e;
    endfunction

    function automatic exp_t mk(input logic de, input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        e.v = 1'b1; e.de = de; e.ctrl = c; e.data = d;
        return e;
    endfunction

    function automatic logic [9:0] rand_data_word();
        logic [9:0] w;
        do w = 10'($urandom); while (is_tok(w));
        return w;
    endfunction

    // One clock: drive inputs, step the two-deep expectation pipe, compare.
    task automatic tick(input logic rst, input logic v, input logic [9:0] w, input exp_t e);
        reset    = rst;
        in_valid = v;
        in_word  = w;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            p1 = '0;
            p2 = '0;
        end else begin
            p2   = p1;
            p1   = e;
            p1.v = v;
        end
        chk("out_valid", out_valid, p2.v);
        if (p2.v) begin
            chk("out_de", out_de, p2.de);
            if (!p2.de) chk("out_ctrl", out_ctrl, p2.ctrl);
            chk("out_data", out_data, p2.data);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] w);
        tick(1'b0, v, w, model(v, w));
    endtask

    logic [9:0] toks [4];
    logic       bq [$];
    int         slip_t [$];
    int         nv;
    int         slips;
    int         dropped;
    int         sym_idx;
    logic       prev_slip;
    logic       slip_seen;
    logic [9:0] w;
    logic [9:0] sw;

    initial begin
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
        reset = 1'b1; in_valid = 1'b0; in_word = '0;

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 10'h000, '0);
        chk("rst_bitslip", bitslip, 0);
        chk("rst_locked", locked, 0);
        chk("rst_de", out_de, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_data", out_data, 0);

        // Lock on a run of 00 tokens: locked right after the 8th one
        for (int j = 1; j <= 12; j++) begin
            drive(1'b1, 10'h354);
            chk("lock_run", locked, (j >= 8));
        end

        // Known data words
        tick(1'b0, 1'b1, 10'h100, mk(1'b1, 2'b00, 8'h00));
        tick(1'b0, 1'b1, 10'h200, mk(1'b1, 2'b00, 8'hFF));
        for (int i = 0; i < 4; i++) drive(1'b1, toks[i]);

        // Encoder round trip, both disparity forms of every byte
        for (int b = 0; b < 256; b++) begin
            tick(1'b0, 1'b1, enc(8'(b), 1'b0), mk(1'b1, 2'b00, 8'(b)));
            tick(1'b0, 1'b1, enc(8'(b), 1'b1), mk(1'b1, 2'b00, 8'(b)));
        end
        chk("lock_held_data", locked, 1);
        for (int i = 0; i < 10; i++) drive(1'b1, toks[i % 4]);
        chk("lock_held_tok", locked, 1);

        // Reset mid-stream while locked
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 10'h354, '0);
            chk("mrst_locked", locked, 0);
            chk("mrst_bitslip", bitslip, 0);
            chk("mrst_de", out_de, 0);
            chk("mrst_ctrl", out_ctrl, 0);
            chk("mrst_data", out_data, 0);
        end
        drive(1'b1, rand_data_word());
        chk("post_rst_locked", locked, 0);

        // Gapped token run: lock after 8 valid tokens, invalid beats ignored
        nv = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                drive(1'b1, 10'h154);
                nv++;
            end else begin
                drive(1'b0, rand_data_word());
            end
            chk("gap_lock", locked, (nv >= 8));
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 10'h2AB);

        // Lock loss after SEARCH_TIMEOUT data words, no bitslip
        slips = 0;
        for (int n = 1; n <= 2048; n++) begin
            drive(1'b1, rand_data_word());
            chk("lockloss", locked, (n < 2048));
            if (bitslip) slips++;
        end
        chk("lockloss_slips", slips, 0);

        // Random mix of tokens, data and idle beats
        prev_slip = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            w = ($urandom_range(0, 2) == 0) ? toks[$urandom_range(0, 3)] : 10'($urandom);
            drive($urandom_range(0, 3) != 0, w);
            chk("slip_pair", (bitslip && prev_slip), 0);
            prev_slip = bitslip;
        end

        // Misaligned serial stream; each bitslip drops one bit
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 10'h000, '0);
        bq.delete();
        slip_t.delete();
        sym_idx = 0;
        dropped = 7;
        slip_seen = 1'b0;
        prev_slip = 1'b0;
        for (int t = 0; t < 12000 && !locked; t++) begin
            while (bq.size() < 24) begin
                sw = (sym_idx % 140 < 40) ? 10'h354 : enc(8'($urandom), 1'($urandom));
                sym_idx++;
                for (int b = 0; b < 10; b++) bq.push_back(sw[b]);
            end
            if (t == 0)
                for (int b = 0; b < 7; b++) void'(bq.pop_front());
            if (slip_seen) begin
                void'(bq.pop_front());
                dropped++;
            end
            for (int b = 0; b < 10; b++) w[b] = bq.pop_front();
            drive(1'b1, w);
            if (bitslip) slip_t.push_back(cyc);
            if (bitslip && prev_slip) chk("mis_slip_pair", 1, 0);
            prev_slip = bitslip;
            slip_seen = bitslip;
        end
        chk("mis_locked", locked, 1);
        chk("mis_slips", slip_t.size(), 3);
        chk("mis_aligned", dropped % 10, 0);
        if (slip_t.size() >= 3) begin
            chk("mis_gap1", (slip_t[1] - slip_t[0]) >= (SEARCH_TIMEOUT + SLIP_WAIT), 1);
            chk("mis_gap2", (slip_t[2] - slip_t[1]) >= (SEARCH_TIMEOUT + SLIP_WAIT), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
